// File: rtl/i2s_line_in_receiver_if.sv
// Bundle between the ADAU1761 ADC-side I2S pins and the line-in sample consumers.
// new_frame is a valid strobe with no ready: sample_l/sample_r are valid and stable whenever
// new_frame is high and hold until the next strobe, so a consumer may take them then or later.
interface i2s_line_in_receiver_if #(
    parameter int SAMPLE_WIDTH = 24
);
    logic                    i2s_bclk;
    logic                    i2s_lr;
    logic                    i2s_sdata;
    logic [SAMPLE_WIDTH-1:0] sample_l;
    logic [SAMPLE_WIDTH-1:0] sample_r;
    logic                    new_frame;
    logic                    frame_err;
    logic [1:0]              state_dbg;

    modport master (
        input  i2s_bclk,
        input  i2s_lr,
        input  i2s_sdata,
        output sample_l,
        output sample_r,
        output new_frame,
        output frame_err,
        output state_dbg
    );

    modport slave (
        output i2s_bclk,
        output i2s_lr,
        output i2s_sdata,
        input  sample_l,
        input  sample_r,
        input  new_frame,
        input  frame_err,
        input  state_dbg
    );
endinterface

// File: rtl/i2s_line_in_receiver.sv
// Oversampling I2S receiver: deserialises codec ADC data into left/right sample pairs in the
// clk domain, publishing both channels together with a one-cycle new_frame strobe.
module i2s_line_in_receiver #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int SLOT_BITS    = 32
) (
    input logic                    clk,
    input logic                    reset,
    i2s_line_in_receiver_if.master bus
);
    localparam int IDX_W = $clog2(SLOT_BITS + 2);
    localparam logic [IDX_W-1:0] IDX_SAT  = IDX_W'(SLOT_BITS + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SAMPLE_WIDTH);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT_L = 2'd1;
    localparam logic [1:0] ST_WAIT_R = 2'd2;

    // synchronisers
    logic s1_bclk, s2_bclk, b3_bclk;
    logic s1_lr, s2_lr;
    logic s1_sdata, s2_sdata;

    // slot tracking and capture
    logic                    lr_last;
    logic                    lr_primed;
    logic                    armed;
    logic                    chan;
    logic [IDX_W-1:0]        bit_idx;
    logic [SAMPLE_WIDTH-2:0] shreg;
    logic [SAMPLE_WIDTH-1:0] hold_l;
    logic [SAMPLE_WIDTH-1:0] hold_r;
    logic                    word_done;
    logic                    word_chan;
    logic                    short_err;
    logic                    ovr_err;

    // output stage
    logic [1:0]              state;
    logic [SAMPLE_WIDTH-1:0] sample_l;
    logic [SAMPLE_WIDTH-1:0] sample_r;
    logic                    new_frame;
    logic                    frame_err;

    logic             bclk_rise;
    logic             lr_edge;
    logic [IDX_W-1:0] next_idx;
    logic             capture;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_bclk  <= 1'b0;
            s2_bclk  <= 1'b0;
            b3_bclk  <= 1'b0;
            s1_lr    <= 1'b0;
            s2_lr    <= 1'b0;
            s1_sdata <= 1'b0;
            s2_sdata <= 1'b0;
        end else begin
            s1_bclk  <= bus.i2s_bclk;
            s2_bclk  <= s1_bclk;
            b3_bclk  <= s2_bclk;
            s1_lr    <= bus.i2s_lr;
            s2_lr    <= s1_lr;
            s1_sdata <= bus.i2s_sdata;
            s2_sdata <= s1_sdata;
        end
    end

    assign bclk_rise = s2_bclk & ~b3_bclk;
    // The first rise after reset only records lr, so a slot already in progress is never
    // mistaken for a slot start.
    assign lr_edge   = lr_primed && (s2_lr != lr_last);
    assign next_idx  = (bit_idx == IDX_SAT) ? IDX_SAT : bit_idx + IDX_ONE;
    assign capture   = armed && !lr_edge && (next_idx <= IDX_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            lr_last   <= 1'b0;
            lr_primed <= 1'b0;
            armed     <= 1'b0;
            chan      <= 1'b0;
            bit_idx   <= '0;
            shreg     <= '0;
            hold_l    <= '0;
            hold_r    <= '0;
            word_done <= 1'b0;
            word_chan <= 1'b0;
            short_err <= 1'b0;
            ovr_err   <= 1'b0;
        end else begin
            word_done <= 1'b0;
            short_err <= 1'b0;
            ovr_err   <= 1'b0;
            if (bclk_rise) begin
                lr_last   <= s2_lr;
                lr_primed <= 1'b1;
                if (lr_edge) begin
                    // Slot start: this bit is the I2S delay bit and carries no data.
                    short_err <= armed && (bit_idx < IDX_LAST);
                    bit_idx   <= '0;
                    chan      <= s2_lr;
                    armed     <= 1'b1;
                end else begin
                    bit_idx <= next_idx;
                    ovr_err <= armed && (bit_idx != IDX_SAT) && (next_idx == IDX_SAT);
                    if (capture) begin
                        shreg <= {shreg[SAMPLE_WIDTH-3:0], s2_sdata};
                        if (next_idx == IDX_LAST) begin
                            word_done <= 1'b1;
                            word_chan <= chan;
                            if (chan) begin
                                hold_r <= {shreg, s2_sdata};
                            end else begin
                                hold_l <= {shreg, s2_sdata};
                            end
                        end
                    end
                end
            end
        end
    end

    // Pairing FSM: a right word only publishes when a left word preceded it in this frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            sample_l  <= '0;
            sample_r  <= '0;
            new_frame <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            new_frame <= 1'b0;
            if (short_err || ovr_err) begin
                frame_err <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (armed) begin
                        state <= ST_WAIT_L;
                    end
                end
                ST_WAIT_L: begin
                    if (word_done && !word_chan) begin
                        state <= ST_WAIT_R;
                    end
                end
                ST_WAIT_R: begin
                    if (word_done && word_chan) begin
                        sample_l  <= hold_l;
                        sample_r  <= hold_r;
                        new_frame <= 1'b1;
                        state     <= ST_WAIT_L;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.sample_l  = sample_l;
    assign bus.sample_r  = sample_r;
    assign bus.new_frame = new_frame;
    assign bus.frame_err = frame_err;
    assign bus.state_dbg = state;
endmodule

// File: doc/i2s_line_in_receiver.md
Name: i2s_line_in_receiver

Overview:
- Deserialises ADC capture data from the ADAU1761 I2S port into parallel left/right samples in the clk domain.
- Feeds line_in_l/line_in_r consumers: record/loopback path and wave display. Transmit direction is unchanged.
- Codec is I2S master: bit clock, LR clock and data are asynchronous inputs, oversampled by clk.

Parameters:
- SAMPLE_WIDTH, 24, bits captured per channel, MSB first.
- SLOT_BITS, 32, nominal BCLK periods per channel slot; used only for overrun detection.

Ports:
- clk input 1: system clock, 100 MHz.
- reset input 1: synchronous, active-high.
- i2s_bclk input 1: codec bit clock, raw/asynchronous.
- i2s_lr input 1: codec LR clock, raw; 0 = left slot, 1 = right slot.
- i2s_sdata input 1: codec ADC serial data, raw.
- sample_l output SAMPLE_WIDTH: last complete left sample, two's complement.
- sample_r output SAMPLE_WIDTH: last complete right sample.
- new_frame output 1: one-cycle pulse when a left+right pair has been updated.
- frame_err output 1: sticky slot-length error flag.

Behaviour:
- Synchronisation
  - Each raw input passes through 2 flops: s1, then s2. A third flop on bclk (b3) gives edge detect.
  - bclk_rise = s2_bclk & ~b3. lr and sdata use their s2 values in the same cycle.
  - Precondition: bclk high and low phases are each at least 3 clk cycles.
- Slot tracking: on each bclk_rise, compare s2_lr with lr_last (lr value at the previous bclk_rise).
  - If they differ: slot start. bit_idx <= 0 (I2S delay bit, data ignored), chan <= s2_lr, armed <= 1.
  - Else: bit_idx <= bit_idx + 1, saturating at SLOT_BITS+1.
- Capture
  - While armed and 1 <= bit_idx+1 <= SAMPLE_WIDTH, shift s2_sdata into shreg LSB-first-in, giving MSB-first order.
  - When the bit with index SAMPLE_WIDTH is shifted: write {shreg, bit} to hold_l if chan = 0, or to hold_r if chan = 1.
  - Bits with index greater than SAMPLE_WIDTH are ignored.
- State machine: IDLE -> WAIT_L -> WAIT_R -> WAIT_L ...
  - IDLE (after reset): armed = 0. Nothing is captured until the first lr transition, so a partial slot is always discarded.
  - WAIT_L: left word completes -> WAIT_R.
  - WAIT_R: right word completes -> sample_l <= hold_l, sample_r <= new right word, new_frame <= 1 for exactly one cycle, then -> WAIT_L.
  - A right word completing while in WAIT_L (left slot lost) gives no new_frame and stays in WAIT_L.
- Latency: raw bclk rising edge first sampled at clk edge k -> outputs and new_frame change at edge k+3.
- Errors: frame_err sets and holds until reset in either case:
  - an lr transition while armed and the slot had fewer than SAMPLE_WIDTH+1 bit periods (short slot; partial word discarded, no write);
  - bit_idx reaching SLOT_BITS+1 (overrun).
- Reset: sample_l = 0, sample_r = 0, new_frame = 0, frame_err = 0, state = IDLE, all synchroniser flops = 0. Reset asserted mid-slot abandons the word; capture resumes only after the next lr transition following deassert.
- Outputs hold their values between frames and never update partially: sample_l and sample_r always change in the same cycle.

Test Plan:
- Standard frame: reset, then 64-BCLK frame with BCLK period 32 clk, left = 24'h123456, right = 24'hABCDEF -> after the right LSB, new_frame is a single pulse; sample_l = 24'h123456, sample_r = 24'hABCDEF; frame_err = 0.
- Start mid-right-slot after reset: first partial slot with junk data, then left = 24'h000001, right = 24'hFFFFFF -> only one new_frame, carrying exactly those values; partial slot ignored.
- Latency: drive the bclk rising edge carrying the right LSB aligned to clk edge k -> new_frame high during the cycle after edge k+3 only; outputs stable before that.
- Short slot: lr toggles after 10 bits of a left word -> frame_err = 1 and stays 1; no new_frame for that frame; next full frame (left = 24'h800000, right = 24'h7FFFFF) still updates outputs.
- Overrun: hold lr constant for 40 BCLKs -> frame_err = 1.
- Reset mid-frame: assert reset for 1 clk during bit 12 of the right slot -> all outputs 0; the following complete frame with 24'h00FF00 / 24'h0F0F0F produces one new_frame with those values.
